fractal_sync_nd_rf: RTL and testbench
=====================================

# fractal_sync_nd_rf

Parametrised N-dimensional synchronisation register file for the fractal sync tree node, replacing the fixed 1D/2D variants. Each dimension owns one port pair (two ports), a bank of local barrier flags indexed by id, and a remote CAM keyed by {level, id}. All responses are registered. Remote entries can optionally expire through a per-entry timeout so that a lost partner frees CAM capacity.

## Interface
Parameters:
- N_DIMS, default 2: number of dimensions; port p = 2*d + k (d = dimension, k = 0/1 side).
- N_LOCAL_REGS, default 2: local flags per dimension.
- LEVEL_WIDTH, default 1: level field width.
- ID_WIDTH, default 1: id field width.
- N_REMOTE_LINES, default 2: CAM entries per dimension.
- TIMEOUT_CYCLES, default 1024: entry lifetime; only used with the timeout macro.
- N_PORTS (localparam) = 2*N_DIMS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, reset asynchronous and active-high.
- clear_i  in  1  synchronous flush of all local flags and CAM entries.
- level_i[N_PORTS]  in  LEVEL_WIDTH  level of request.
- id_i[N_PORTS]  in  ID_WIDTH  barrier id.
- check_local_i[N_PORTS]  in  1  local lookup strobe.
- check_remote_i[N_PORTS]  in  1  remote lookup strobe (mutually exclusive with local on the same port).
- present_local_o[N_PORTS]  out  1  local barrier completed.
- present_remote_o[N_PORTS]  out  1  remote barrier completed.
- id_err_o[N_PORTS]  out  1  local id out of range or over-subscribed.
- sig_err_o[N_PORTS]  out  1  remote CAM full or over-subscribed.
- bypass_local_o[N_DIMS]  out  1  both ports of dim met locally in one cycle.
- bypass_remote_o[N_DIMS]  out  1  both ports of dim met remotely in one cycle.
- timeout_o[N_DIMS]  out  1  pulse: at least one CAM entry of dim expired.

## Operation
Dimensions are fully independent. Local path, per port with check_local_i:
- id >= N_LOCAL_REGS: id_err=1, no state change.
- Flag clear, single requester: set flag, present=0.
- Flag set, single requester: present=1, clear flag.
- Both ports, same id, flag clear: present=1 on both, bypass_local=1, flag stays clear.
- Both ports, same id, flag set: id_err=1 on both, flag cleared.
- Both ports, different ids: each handled as a single requester.

Remote path, per port with check_remote_i, key = {level, id}:
- Hit on a valid entry: present=1, entry invalidated.
- Miss: allocate lowest-index free entry, present=0.
- Miss with no free entry: sig_err=1, no state change.
- Both ports, same key, no hit: present=1 on both, bypass_remote=1, no allocation.
- Both ports, same key, hit: sig_err=1 on both, entry invalidated.
- Both ports, different keys, both miss, one free entry: port k=0 allocates, port k=1 gets sig_err.
- Both ports hitting different entries: both present.

clear_i: all flags and entries are invalidated. Checks in that cycle are ignored, and all outputs are 0 in the next cycle.

## Timing
- All outputs are registered. A response appears exactly one cycle after the check strobe, as a single-cycle pulse.
- State updates at the same edge that registers the response. A check in cycle t+1 sees the update from cycle t (no forwarding hazard).
- Reset: all outputs 0, all flags 0, all entries invalid, all counters 0. Reset asserted mid-operation drops pending state immediately.
- Back-to-back checks are accepted every cycle on every port. There is no backpressure.

## Configuration
- FRACTAL_SYNC_RF_TIMEOUT_EN defined:
  - Each CAM entry has an age counter of width $clog2(TIMEOUT_CYCLES+1), zeroed on allocation.
  - An entry allocated in cycle t is freed at the end of cycle t+TIMEOUT_CYCLES. timeout_o[d] pulses in the following cycle.
  - A hit in the expiry cycle wins: present=1, no timeout pulse.
  - A freed entry is allocatable in the next cycle.
- Macro undefined: entries persist until hit or clear_i, no counters are built, and timeout_o is tied 0.

## Test plan
- N_DIMS=3, port 2 local id 1, then port 3 local id 1 two cycles later -> present_local_o[2]=0, then present_local_o[3]=1 one cycle after its check, flag cleared.
- Ports 0 and 1 local id 0 in the same cycle -> present_local_o[0]=present_local_o[1]=1 and bypass_local_o[0]=1 next cycle. Local id 2 with N_LOCAL_REGS=2 -> id_err_o=1.
- N_REMOTE_LINES=2, three distinct remote keys on dim 0 over three cycles -> third gets sig_err_o=1. Matching key for the first key -> present_remote_o=1, freeing the entry for reuse.
- Ports 0/1 different missing keys with one free entry -> port 0 allocates, sig_err_o[1]=1.
- Timeout enabled, TIMEOUT_CYCLES=8, allocate at cycle 10 -> timeout_o[0]=1 at cycle 19, and the later matching key misses and allocates. Hit at cycle 18 -> present=1, no timeout.
- Allocate entries, assert clear_i together with a hitting check -> outputs 0 the next cycle. Then assert rst_i asynchronously mid-stream -> all outputs drop to 0 immediately, CAM empty.

Source files
------------

// File: rtl/fractal_sync_nd_rf.sv
// fractal_sync_nd_rf: N-dimensional synchronisation register file for a
// fractal sync tree node. Each dimension owns two ports, a bank of local
// barrier flags indexed by id, and a remote CAM keyed by {level, id}.
// All responses are registered one cycle after the check strobe.
// Optional feature macro: FRACTAL_SYNC_RF_TIMEOUT_EN adds per-entry age
// counters so that a CAM entry expires after TIMEOUT_CYCLES cycles.

// One dimension: ports k=0 and k=1 share the flags and the CAM.
module fractal_sync_nd_rf_dim #(
  parameter int N_LOCAL_REGS   = 2,
  parameter int LEVEL_WIDTH    = 1,
  parameter int ID_WIDTH       = 1,
  parameter int N_REMOTE_LINES = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [1:0][LEVEL_WIDTH-1:0] level_i,
  input  logic [1:0][ID_WIDTH-1:0]    id_i,
  input  logic [1:0]                  check_local_i,
  input  logic [1:0]                  check_remote_i,
  output logic [1:0]                  present_local_o,
  output logic [1:0]                  present_remote_o,
  output logic [1:0]                  id_err_o,
  output logic [1:0]                  sig_err_o,
  output logic                        bypass_local_o,
  output logic                        bypass_remote_o,
  output logic                        timeout_o
);
  localparam int KW = LEVEL_WIDTH + ID_WIDTH;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [N_LOCAL_REGS-1:0]             flags_q, flags_n;
  logic [1:0]                          rng, fset, pl_n, ie_n;
  logic                                bl_n;
  logic [N_REMOTE_LINES-1:0]           valid_q, valid_n, alloc;
  logic [N_REMOTE_LINES-1:0][KW-1:0]   key_q, key_n;
  logic [1:0][KW-1:0]                  key;
  logic [1:0][N_REMOTE_LINES-1:0]      hit;
  logic [1:0]                          pr_n, se_n;
  logic                                br_n, tmo_n, found;

`ifdef FRACTAL_SYNC_RF_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [N_REMOTE_LINES-1:0][AGE_W-1:0] age_q, age_n;
`endif

  assign key[0] = {level_i[0], id_i[0]};
  assign key[1] = {level_i[1], id_i[1]};

  // Local flag lookup: range check and current flag value per port.
  always_comb begin
    rng  = '0;
    fset = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N_LOCAL_REGS; i++)
        if (id_i[k] == ID_WIDTH'(i)) begin
          rng[k]  = 1'b1;
          fset[k] = flags_q[i];
        end
  end

  // Local barrier resolution; a same-id pair is resolved jointly.
  always_comb begin
    flags_n = flags_q;
    pl_n    = '0;
    ie_n    = '0;
    bl_n    = 1'b0;
    if (&check_local_i && id_i[0] == id_i[1]) begin
      if (!rng[0]) begin
        ie_n = 2'b11;
      end else if (fset[0]) begin
        // Flag already held by an earlier requester: three-way over-subscription.
        ie_n = 2'b11;
        for (int i = 0; i < N_LOCAL_REGS; i++)
          if (id_i[0] == ID_WIDTH'(i)) flags_n[i] = 1'b0;
      end else begin
        pl_n = 2'b11;
        bl_n = 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (check_local_i[k]) begin
          if (!rng[k]) begin
            ie_n[k] = 1'b1;
          end else begin
            pl_n[k] = fset[k];
            for (int i = 0; i < N_LOCAL_REGS; i++)
              if (id_i[k] == ID_WIDTH'(i)) flags_n[i] = !fset[k];
          end
        end
    end
  end

  // CAM match against the start-of-cycle contents.
  always_comb begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < N_REMOTE_LINES; j++)
        hit[k][j] = valid_q[j] && key_q[j] == key[k];
  end

  // Remote resolution: hits invalidate, misses take the lowest free line,
  // port 0 allocating before port 1. Lines freed this cycle are not reused
  // until the next cycle.
  always_comb begin
    valid_n = valid_q;
    key_n   = key_q;
    alloc   = '0;
    pr_n    = '0;
    se_n    = '0;
    br_n    = 1'b0;
    tmo_n   = 1'b0;
    found   = 1'b0;
    if (&check_remote_i && key[0] == key[1]) begin
      if (|hit[0]) begin
        se_n    = 2'b11;
        valid_n = valid_q & ~hit[0];
      end else begin
        pr_n = 2'b11;
        br_n = 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (check_remote_i[k]) begin
          if (|hit[k]) begin
            pr_n[k] = 1'b1;
            valid_n = valid_n & ~hit[k];
          end else begin
            found = 1'b0;
            for (int j = 0; j < N_REMOTE_LINES; j++)
              if (!found && !valid_q[j] && !alloc[j]) begin
                found      = 1'b1;
                alloc[j]   = 1'b1;
                valid_n[j] = 1'b1;
                key_n[j]   = key[k];
              end
            se_n[k] = !found;
          end
        end
    end
`ifdef FRACTAL_SYNC_RF_TIMEOUT_EN
    age_n = '0;
    for (int j = 0; j < N_REMOTE_LINES; j++) begin
      age_n[j] = (valid_q[j] && !alloc[j]) ? age_q[j] + 1'b1 : '0;
      // An entry hit in its last cycle is already gone from valid_n, so the hit wins.
      if (valid_n[j] && valid_q[j] && age_q[j] == AGE_W'(TIMEOUT_CYCLES - 1)) begin
        valid_n[j] = 1'b0;
        tmo_n      = 1'b1;
      end
    end
`endif
  end

  // State and registered responses; clear_i flushes and silences the next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      flags_q          <= '0;
      valid_q          <= '0;
      key_q            <= '0;
      present_local_o  <= '0;
      present_remote_o <= '0;
      id_err_o         <= '0;
      sig_err_o        <= '0;
      bypass_local_o   <= 1'b0;
      bypass_remote_o  <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      flags_q          <= flags_n;
      valid_q          <= valid_n;
      key_q            <= key_n;
      present_local_o  <= pl_n;
      present_remote_o <= pr_n;
      id_err_o         <= ie_n;
      sig_err_o        <= se_n;
      bypass_local_o   <= bl_n;
      bypass_remote_o  <= br_n;
      timeout_o        <= tmo_n;
    end
  end

`ifdef FRACTAL_SYNC_RF_TIMEOUT_EN
  // Per-entry age counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) age_q <= '0;
    else                  age_q <= age_n;
  end
`endif
endmodule

module fractal_sync_nd_rf #(
  parameter  int N_DIMS         = 2,
  parameter  int N_LOCAL_REGS   = 2,
  parameter  int LEVEL_WIDTH    = 1,
  parameter  int ID_WIDTH       = 1,
  parameter  int N_REMOTE_LINES = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int N_PORTS        = 2 * N_DIMS
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] level_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]  id_i,
  input  logic [N_PORTS-1:0]                check_local_i,
  input  logic [N_PORTS-1:0]                check_remote_i,
  output logic [N_PORTS-1:0]                present_local_o,
  output logic [N_PORTS-1:0]                present_remote_o,
  output logic [N_PORTS-1:0]                id_err_o,
  output logic [N_PORTS-1:0]                sig_err_o,
  output logic [N_DIMS-1:0]                 bypass_local_o,
  output logic [N_DIMS-1:0]                 bypass_remote_o,
  output logic [N_DIMS-1:0]                 timeout_o
);
  for (genvar d = 0; d < N_DIMS; d++) begin : g_dim
    fractal_sync_nd_rf_dim #(
      .N_LOCAL_REGS  (N_LOCAL_REGS),
      .LEVEL_WIDTH   (LEVEL_WIDTH),
      .ID_WIDTH      (ID_WIDTH),
      .N_REMOTE_LINES(N_REMOTE_LINES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_dim (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .clear_i         (clear_i),
      .level_i         (level_i[2*d +: 2]),
      .id_i            (id_i[2*d +: 2]),
      .check_local_i   (check_local_i[2*d +: 2]),
      .check_remote_i  (check_remote_i[2*d +: 2]),
      .present_local_o (present_local_o[2*d +: 2]),
      .present_remote_o(present_remote_o[2*d +: 2]),
      .id_err_o        (id_err_o[2*d +: 2]),
      .sig_err_o       (sig_err_o[2*d +: 2]),
      .bypass_local_o  (bypass_local_o[d]),
      .bypass_remote_o (bypass_remote_o[d]),
      .timeout_o       (timeout_o[d])
    );
  end
endmodule

// File: tb/tb_fractal_sync_nd_rf.sv
// Testbench for fractal_sync_nd_rf: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the barrier rules.
module tb_fractal_sync_nd_rf;
  localparam int ND = 3, NP = 6, NL = 2, LW = 1, IW = 2, NR = 2, TO = 8;
`ifdef FRACTAL_SYNC_RF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear;
  logic [NP-1:0][LW-1:0] level;
  logic [NP-1:0][IW-1:0] id;
  logic [NP-1:0] cl, cr;
  logic [NP-1:0] pl, pr, ie, se;
  logic [ND-1:0] bl, br, tmo;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fractal_sync_nd_rf #(
    .N_DIMS(ND), .N_LOCAL_REGS(NL), .LEVEL_WIDTH(LW), .ID_WIDTH(IW),
    .N_REMOTE_LINES(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .level_i(level), .id_i(id),
    .check_local_i(cl), .check_remote_i(cr),
    .present_local_o(pl), .present_remote_o(pr), .id_err_o(ie), .sig_err_o(se),
    .bypass_local_o(bl), .bypass_remote_o(br), .timeout_o(tmo)
  );

  // Behavioural model: flags per dim/id, CAM lines remember their allocation cycle.
  bit mflag [ND][NL];
  bit mval [ND][NR];
  int mkey [ND][NR];
  int malloc [ND][NR];
  int cyc;
  logic [NP-1:0] e_pl, e_pr, e_ie, e_se;
  logic [ND-1:0] e_bl, e_br, e_to;
  logic [7:0] got, want;
  bit dchk;

  function automatic void model_reset();
    foreach (mflag[d, i]) mflag[d][i] = 1'b0;
    foreach (mval[d, j]) mval[d][j] = 1'b0;
  endfunction

  function automatic int key_of(int p);
    return int'(level[p]) * (1 << IW) + int'(id[p]);
  endfunction

  function automatic int find(int d, int k);
    for (int j = 0; j < NR; j++) if (mval[d][j] && mkey[d][j] == k) return j;
    return -1;
  endfunction

  function automatic void model_step();
    bit sval [NR];
    int a, b, h, f, ka, kb, kp, p, ix;
    e_pl = '0; e_pr = '0; e_ie = '0; e_se = '0; e_bl = '0; e_br = '0; e_to = '0;
    if (clear) begin
      model_reset();
      cyc++;
      return;
    end
    for (int d = 0; d < ND; d++) begin
      a = 2 * d; b = a + 1;
      // local barrier rules
      if (cl[a] && cl[b] && id[a] == id[b]) begin
        ix = int'(id[a]);
        if (ix >= NL) begin e_ie[a] = 1'b1; e_ie[b] = 1'b1; end
        else if (mflag[d][ix]) begin e_ie[a] = 1'b1; e_ie[b] = 1'b1; mflag[d][ix] = 1'b0; end
        else begin e_pl[a] = 1'b1; e_pl[b] = 1'b1; e_bl[d] = 1'b1; end
      end else begin
        for (int s = 0; s < 2; s++) begin
          p = a + s; ix = int'(id[p]);
          if (cl[p]) begin
            if (ix >= NL) e_ie[p] = 1'b1;
            else if (mflag[d][ix]) begin e_pl[p] = 1'b1; mflag[d][ix] = 1'b0; end
            else mflag[d][ix] = 1'b1;
          end
        end
      end
      // remote barrier rules
      ka = key_of(a); kb = key_of(b);
      for (int j = 0; j < NR; j++) sval[j] = mval[d][j];
      if (cr[a] && cr[b] && ka == kb) begin
        h = find(d, ka);
        if (h >= 0) begin e_se[a] = 1'b1; e_se[b] = 1'b1; mval[d][h] = 1'b0; end
        else begin e_pr[a] = 1'b1; e_pr[b] = 1'b1; e_br[d] = 1'b1; end
      end else begin
        for (int s = 0; s < 2; s++) begin
          p = a + s;
          if (cr[p]) begin
            kp = key_of(p); h = find(d, kp);
            if (h >= 0) begin
              e_pr[p] = 1'b1; mval[d][h] = 1'b0;
            end else begin
              f = -1;
              for (int j = 0; j < NR; j++) if (f < 0 && !sval[j] && !mval[d][j]) f = j;
              if (f < 0) e_se[p] = 1'b1;
              else begin mval[d][f] = 1'b1; mkey[d][f] = kp; malloc[d][f] = cyc; end
            end
          end
        end
      end
      if (TO_EN)
        for (int j = 0; j < NR; j++)
          if (sval[j] && mval[d][j] && malloc[d][j] + TO == cyc) begin
            mval[d][j] = 1'b0; e_to[d] = 1'b1;
          end
    end
    cyc++;
  endfunction

  task automatic idle();
    clear = 1'b0; cl = '0; cr = '0; id = '0; level = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    repeat (3) @(posedge clk);
    #1;
    if ({pl, pr, ie, se, bl, br, tmo} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {pl, pr, ie, se, bl, br, tmo});
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_local();
    for (int s = 0; s < 7; s++) begin
      idle();
      case (s)
        0: begin cl[2] = 1'b1; id[2] = 2'd1; end
        2: begin cl[3] = 1'b1; id[3] = 2'd1; end
        3: begin cl[1:0] = 2'b11; id[0] = 2'd0; id[1] = 2'd0; end
        4: begin cl[4] = 1'b1; id[4] = 2'd2; cl[0] = 1'b1; id[0] = 2'd1; end
        5: begin cl[1:0] = 2'b11; id[0] = 2'd1; id[1] = 2'd1; end
        6: begin cl[2] = 1'b1; id[2] = 2'd1; end
        default: ;
      endcase
      tick();
      if ({pl, pr, ie, se, bl, br, tmo} !== {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to}) begin
        failures++;
        $display("FAIL local_model step=%0d got=%h want=%h", s,
                 {pl, pr, ie, se, bl, br, tmo}, {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to});
      end
      checks++;
      dchk = 1'b1;
      case (s)
        0: begin got = {7'd0, pl[2]}; want = 8'd0; end
        2: begin got = {7'd0, pl[3]}; want = 8'd1; end
        3: begin got = {5'd0, pl[1:0], bl[0]}; want = 8'b111; end
        4: begin got = {6'd0, ie[4], pl[0]}; want = 8'b10; end
        5: begin got = {6'd0, ie[1:0]}; want = 8'b11; end
        6: begin got = {7'd0, pl[2]}; want = 8'd0; end
        default: dchk = 1'b0;
      endcase
      if (dchk) begin
        if (got !== want) begin
          failures++;
          $display("FAIL local_directed step=%0d got=%b want=%b", s, got, want);
        end
        checks++;
      end
    end
  endtask

  task automatic test_remote();
    for (int s = 0; s < 11; s++) begin
      idle();
      case (s)
        0: begin cr[0] = 1'b1; level[0] = 1'b0; id[0] = 2'd0; end
        1: begin cr[1] = 1'b1; level[1] = 1'b0; id[1] = 2'd1; end
        2: begin cr[0] = 1'b1; level[0] = 1'b1; id[0] = 2'd2; end
        3: begin cr[1] = 1'b1; level[1] = 1'b0; id[1] = 2'd0; end
        4: begin cr[0] = 1'b1; level[0] = 1'b1; id[0] = 2'd2; end
        5: begin cr[0] = 1'b1; level[0] = 1'b0; id[0] = 2'd1; end
        6: begin cr[1:0] = 2'b11; level[0] = 1'b1; id[0] = 2'd3; level[1] = 1'b0; id[1] = 2'd3; end
        7: begin cr[3:2] = 2'b11; id[2] = 2'd2; id[3] = 2'd2; end
        8: begin cr[2] = 1'b1; level[2] = 1'b1; id[2] = 2'd1; end
        9: begin cr[3:2] = 2'b11; level[3:2] = 2'b11; id[2] = 2'd1; id[3] = 2'd1; end
        10: begin cr[1:0] = 2'b11; level[1:0] = 2'b11; id[0] = 2'd2; id[1] = 2'd3; end
        default: ;
      endcase
      tick();
      if ({pl, pr, ie, se, bl, br, tmo} !== {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to}) begin
        failures++;
        $display("FAIL remote_model step=%0d got=%h want=%h", s,
                 {pl, pr, ie, se, bl, br, tmo}, {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to});
      end
      checks++;
      dchk = 1'b1;
      case (s)
        2: begin got = {7'd0, se[0]}; want = 8'd1; end
        3: begin got = {7'd0, pr[1]}; want = 8'd1; end
        4: begin got = {6'd0, pr[0], se[0]}; want = 8'b00; end
        6: begin got = {6'd0, se[1], se[0]}; want = 8'b10; end
        7: begin got = {5'd0, pr[3:2], br[1]}; want = 8'b111; end
        9: begin got = {6'd0, se[3:2]}; want = 8'b11; end
        10: begin got = {6'd0, pr[1:0]}; want = 8'b11; end
        default: dchk = 1'b0;
      endcase
      if (dchk) begin
        if (got !== want) begin
          failures++;
          $display("FAIL remote_directed step=%0d got=%b want=%b", s, got, want);
        end
        checks++;
      end
    end
  endtask

  task automatic test_timeout();
    for (int ph = 0; ph < 2; ph++) begin
      idle();
      clear = 1'b1;
      tick();
      for (int s = 0; s < 10; s++) begin
        idle();
        if (s == 0) begin cr[4] = 1'b1; level[4] = 1'b1; id[4] = 2'd1; end
        if (s == 8 && ph == 1) begin cr[5] = 1'b1; level[5] = 1'b1; id[5] = 2'd1; end
        if (s == 9 && ph == 0) begin cr[4] = 1'b1; level[4] = 1'b1; id[4] = 2'd1; end
        tick();
        if ({pl, pr, ie, se, bl, br, tmo} !== {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to}) begin
          failures++;
          $display("FAIL timeout_model ph=%0d step=%0d got=%h want=%h", ph, s,
                   {pl, pr, ie, se, bl, br, tmo}, {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to});
        end
        checks++;
        // timeout pulse lands exactly TIMEOUT_CYCLES+1 cycles after allocation
        if (ph == 0 && s >= 7) begin
          got = {6'd0, tmo[2], pr[4]};
          want = (s == 8) ? {7'd0, TO_EN} : {6'd0, 1'b0, !TO_EN && s == 9};
          if (got !== want) begin
            failures++;
            $display("FAIL timeout_expiry step=%0d got=%b want=%b", s, got, want);
          end
          checks++;
        end
        if (ph == 1 && s >= 8) begin
          got = {6'd0, tmo[2], pr[5]};
          want = (s == 8) ? 8'b01 : 8'b00;
          if (got !== want) begin
            failures++;
            $display("FAIL timeout_hit_wins step=%0d got=%b want=%b", s, got, want);
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_clear();
    for (int s = 0; s < 3; s++) begin
      idle();
      cr[0] = (s == 0); cr[1] = (s != 0);
      cl[2] = (s == 0); cl[3] = (s != 0);
      clear = (s == 1);
      tick();
      if ({pl, pr, ie, se, bl, br, tmo} !== {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to}) begin
        failures++;
        $display("FAIL clear_model step=%0d got=%h want=%h", s,
                 {pl, pr, ie, se, bl, br, tmo}, {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to});
      end
      checks++;
      if (s == 1 && {pl, pr, ie, se, bl, br, tmo} !== '0) begin
        failures++;
        $display("FAIL clear_silent got=%h want=0", {pl, pr, ie, se, bl, br, tmo});
      end
      if (s == 1) checks++;
      if (s == 2 && {pr[1], pl[3]} !== 2'b00) begin
        failures++;
        $display("FAIL clear_flushed got=%b want=00", {pr[1], pl[3]});
      end
      if (s == 2) checks++;
    end
  endtask

  task automatic test_async_reset();
    idle();
    cr[2] = 1'b1; cr[4] = 1'b1; level[4] = 1'b1;
    tick();
    idle();
    cr[3] = 1'b1;
    tick();
    if (pr[3] !== e_pr[3] || pr[3] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_hit got=%b want=1", pr[3]);
    end
    checks++;
    #2;
    rst = 1'b1;
    #1;
    if ({pl, pr, ie, se, bl, br, tmo} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0", {pl, pr, ie, se, bl, br, tmo});
    end
    checks++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    cr[5] = 1'b1; level[5] = 1'b1;
    tick();
    if ({pr[5], se[5]} !== 2'b00 || {pl, pr, ie, se, bl, br, tmo} !== {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to}) begin
      failures++;
      $display("FAIL reset_cam_empty got=%h want=%h", {pl, pr, ie, se, bl, br, tmo},
               {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to});
    end
    checks++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      idle();
      clear = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 3))
          1: cl[p] = 1'b1;
          2: cr[p] = 1'b1;
          default: ;
        endcase
        id[p] = IW'($urandom_range(0, 3));
        level[p] = LW'($urandom_range(0, 1));
      end
      tick();
      if ({pl, pr, ie, se, bl, br, tmo} !== {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to}) begin
        failures++;
        $display("FAIL random_model cycle=%0d got=%h want=%h", n,
                 {pl, pr, ie, se, bl, br, tmo}, {e_pl, e_pr, e_ie, e_se, e_bl, e_br, e_to});
      end
      checks++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_local();
    test_remote();
    test_timeout();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
